// File: rtl/dmem_responder_if.sv
// Memory-stage data port between the pipelined core (master) and the data memory (slave).
interface dmem_responder_if;
  logic        memenM;
  logic        memwriteM;
  logic [3:0]  selM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        memstallM;
  logic        addrerrM;

  modport master (
    output memenM, memwriteM, selM, aluoutM, writedataM,
    input  readdataM, memstallM, addrerrM
  );

  modport slave (
    input  memenM, memwriteM, selM, aluoutM, writedataM,
    output readdataM, memstallM, addrerrM
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the core for WAIT_CYCLES wait states, then commits a
// byte-lane store or registers a full load word. Misaligned requests are flagged at once.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACCESS, DONE} stateT;

  localparam logic [3:0] waitInit = 4'(WAIT_CYCLES);

  stateT                 state;
  logic [3:0]            waitCnt;
  logic [31:0]           readReg;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            offset;
  logic                  legal;
  logic                  accept;
  logic                  doWrite;
  logic                  unusedAddrBits;

  // Upper address bits are ignored, so the array aliases across the full byte address.
  assign wordIdx        = bus.aluoutM[ADDR_WIDTH+1:2];
  assign offset         = bus.aluoutM[1:0];
  assign unusedAddrBits = ^bus.aluoutM[31:ADDR_WIDTH+2];

  always_comb begin
    legal = 1'b0;
    case (bus.selM)
      4'b0001: legal = (offset == 2'd0);
      4'b0010: legal = (offset == 2'd1);
      4'b0100: legal = (offset == 2'd2);
      4'b1000: legal = (offset == 2'd3);
      4'b0011: legal = (offset == 2'd0);
      4'b1100: legal = (offset == 2'd2);
      4'b1111: legal = (offset == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  assign accept        = bus.memenM & legal;
  assign bus.memstallM = rst & accept & (state != DONE);
  assign bus.addrerrM  = rst & bus.memenM & ~legal;
  assign bus.readdataM = readReg;

  // Gating on rst drops a store whose ACCESS edge coincides with a reset.
  assign doWrite = rst & (state == ACCESS) & bus.memenM & bus.memwriteM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
      readReg <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            waitCnt <= waitInit;
            state   <= (waitInit == 4'd0) ? ACCESS : BUSY;
          end
        end
        BUSY: begin
          if (!bus.memenM) begin
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt - 4'd1;
            if (waitCnt == 4'd1) state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.memenM) begin
            state <= IDLE;
          end else begin
            if (!bus.memwriteM) readReg <= mem[wordIdx];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array is deliberately never reset; only the lanes named in selM are written.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.selM[i]) mem[wordIdx][8*i +: 8] <= bus.writedataM[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (2, 3 and 0 wait states) share one
// request driver; a negedge monitor pops expected responses whenever an access completes.
module tb_dmem_responder;

  localparam int KIND_ACC = 0;
  localparam int KIND_ERR = 1;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          stalls;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          active = 0;
  logic        memen = 1'b0;
  logic        memwrite = 1'b0;
  logic [3:0]  sel = 4'b0000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdMux;
  logic        stallMux;
  logic        errMux;
  int          checks = 0;
  int          passes = 0;
  int          stallCnt = 0;
  expT         sb[$];

  dmem_responder_if bus2 ();
  dmem_responder_if bus3 ();
  dmem_responder_if bus0 ();

  assign bus2.memenM = memen && (active == 0);
  assign bus3.memenM = memen && (active == 1);
  assign bus0.memenM = memen && (active == 2);
  assign bus2.memwriteM = memwrite;
  assign bus3.memwriteM = memwrite;
  assign bus0.memwriteM = memwrite;
  assign bus2.selM = sel;
  assign bus3.selM = sel;
  assign bus0.selM = sel;
  assign bus2.aluoutM = addr;
  assign bus3.aluoutM = addr;
  assign bus0.aluoutM = addr;
  assign bus2.writedataM = wdata;
  assign bus3.writedataM = wdata;
  assign bus0.writedataM = wdata;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  always #5 clk = ~clk;

  always_comb begin
    case (active)
      0: begin
        rdMux = bus2.readdataM; stallMux = bus2.memstallM; errMux = bus2.addrerrM;
      end
      1: begin
        rdMux = bus3.readdataM; stallMux = bus3.memstallM; errMux = bus3.addrerrM;
      end
      default: begin
        rdMux = bus0.readdataM; stallMux = bus0.memstallM; errMux = bus0.addrerrM;
      end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s (dut %0d): got %h, want %h", name, active, act, exp);
  endtask

  // Waits (bounded) for the cycle in which the stall is released, then lets the core advance.
  task automatic waitDone();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stallMux) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("doneReached", 32'(done), 32'd1);
    @(posedge clk);
    #1 memen = 1'b0;
  endtask

  task automatic applyStimulus(input int dutSel, input logic wr, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] wd, input int kind,
                               input logic [31:0] expRd, input int expStalls);
    expT e;
    e.kind   = kind;
    e.data   = expRd;
    e.stalls = expStalls;
    sb.push_back(e);
    @(posedge clk);
    #1;
    active   = dutSel;
    memwrite = wr;
    sel      = s;
    addr     = a;
    wdata    = wd;
    memen    = 1'b1;
    waitDone();
  endtask

  // Monitor: counts stall cycles of the current request and checks each completion or error.
  always @(negedge clk) begin
    if (!rst || !memen) begin
      stallCnt = 0;
    end else if (stallMux) begin
      stallCnt++;
    end else begin
      checkOutput("sbDepth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        expT e;
        e = sb.pop_front();
        checkOutput("addrerr", 32'(errMux), 32'(e.kind == KIND_ERR));
        checkOutput("stallCycles", 32'(stallCnt), 32'(e.stalls));
        checkOutput("readdata", rdMux, e.data);
      end
      stallCnt = 0;
    end
  end

  initial begin
    // Reset held with a request already driven.
    rst = 1'b0; active = 0; memen = 1'b1; memwrite = 1'b1;
    sel = 4'b1111; addr = 32'h2; wdata = 32'h0;
    @(negedge clk);
    checkOutput("rstAddrerr", 32'(errMux), 32'd0);
    sel = 4'b1111; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("rstStall", 32'(stallMux), 32'd0);
    checkOutput("rstAddrerrLegal", 32'(errMux), 32'd0);
    checkOutput("rstReaddata", rdMux, 32'h0);
    checkOutput("rstReaddataW3", bus3.readdataM, 32'h0);
    checkOutput("rstReaddataW0", bus0.readdataM, 32'h0);
    begin
      expT e;
      e.kind = KIND_ACC; e.data = 32'h0; e.stalls = 4;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    waitDone();

    // Two wait states: word round trip, byte lanes, misaligned requests.
    applyStimulus(0, 1'b0, 4'b1111, 32'h40, 32'h0,        KIND_ACC, 32'hDEADBEEF, 4);
    applyStimulus(0, 1'b1, 4'b1111, 32'h8,  32'h11223344, KIND_ACC, 32'hDEADBEEF, 4);
    applyStimulus(0, 1'b1, 4'b0100, 32'hA,  32'h00AA0000, KIND_ACC, 32'hDEADBEEF, 4);
    applyStimulus(0, 1'b0, 4'b1111, 32'h8,  32'h0,        KIND_ACC, 32'h11AA3344, 4);
    applyStimulus(0, 1'b1, 4'b0010, 32'h9,  32'h0000BB00, KIND_ACC, 32'h11AA3344, 4);
    applyStimulus(0, 1'b0, 4'b1111, 32'h8,  32'h0,        KIND_ACC, 32'h11AABB44, 4);
    applyStimulus(0, 1'b1, 4'b1111, 32'h0,  32'hCAFEF00D, KIND_ACC, 32'h11AABB44, 4);
    applyStimulus(0, 1'b1, 4'b1111, 32'h2,  32'h0,        KIND_ERR, 32'h11AABB44, 0);
    applyStimulus(0, 1'b1, 4'b0000, 32'h0,  32'h0,        KIND_ERR, 32'h11AABB44, 0);
    applyStimulus(0, 1'b1, 4'b0011, 32'h1,  32'h0,        KIND_ERR, 32'h11AABB44, 0);
    applyStimulus(0, 1'b0, 4'b1111, 32'h0,  32'h0,        KIND_ACC, 32'hCAFEF00D, 4);
    applyStimulus(0, 1'b1, 4'b1100, 32'h42, 32'h55660000, KIND_ACC, 32'hCAFEF00D, 4);
    applyStimulus(0, 1'b0, 4'b1111, 32'h40, 32'h0,        KIND_ACC, 32'h5566BEEF, 4);

    // Three wait states: a store aborted in BUSY leaves memory untouched.
    applyStimulus(1, 1'b1, 4'b1111, 32'h10, 32'h01234567, KIND_ACC, 32'h0, 5);
    @(posedge clk);
    #1;
    active = 1; memwrite = 1'b1; sel = 4'b1111; addr = 32'h10; wdata = 32'hFFFFFFFF;
    memen = 1'b1;
    @(posedge clk);
    #1 memen = 1'b0;
    applyStimulus(1, 1'b0, 4'b1111, 32'h10, 32'h0, KIND_ACC, 32'h01234567, 5);

    // Zero wait states with an aliased address.
    applyStimulus(2, 1'b1, 4'b1111, 32'h1004, 32'hA5A55A5A, KIND_ACC, 32'h0, 2);
    applyStimulus(2, 1'b0, 4'b1111, 32'h0004, 32'h0,        KIND_ACC, 32'hA5A55A5A, 2);

    @(posedge clk);
    @(negedge clk);
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the slave end of the core's memory-stage data port. It accepts one load or store request at a time from the M stage. It holds the core with `memstallM` for a configurable number of wait states, then commits the store or returns the load word. Byte-lane writes and misaligned-access detection are done here so the core sees only a word-wide, stall-based interface.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: extra wait states per access, legal range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `memenM`  in  1  request valid from the M stage.
- `memwriteM`  in  1  1 = store, 0 = load; valid while `memenM` is high.
- `selM`  in  4  byte-lane mask; bit i corresponds to byte i (bits 8i+7:8i).
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data, already lane-aligned.
- `readdataM`  out  32  load data, full word.
- `memstallM`  out  1  holds the core; the core keeps all request inputs stable while it is high.
- `addrerrM`  out  1  misaligned or illegal-mask request; combinational.

## Operation
- The word index is `aluoutM[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses alias.
- A request is legal only if `selM` matches `aluoutM[1:0]`:
  - 1 byte: `0001<<aluoutM[1:0]`.
  - Halfword: `0011` with `aluoutM[1:0]=00`, or `1100` with `aluoutM[1:0]=10`.
  - Word: `1111` with `aluoutM[1:0]=00`.
  - Anything else, including `0000`, is illegal.
- Illegal request while in IDLE:
  - `addrerrM=1` and `memstallM=0` in that cycle.
  - No array access; the FSM stays in IDLE.
- FSM states:
  - **IDLE**: on a legal `memenM`, load the wait counter with `WAIT_CYCLES`. Go to BUSY, or go directly to ACCESS if `WAIT_CYCLES=0`.
  - **BUSY**: decrement the counter each cycle; when it reaches 0, go to ACCESS.
  - **ACCESS**: perform the operation at the end of this cycle, then go to DONE.
    - Store: writes only the lanes set in `selM`.
    - Load: registers the whole word into `readdataM`.
  - **DONE**: `memstallM=0`. The core advances at the end of this cycle. Unconditionally return to IDLE.
- `memstallM = memenM & legal & (state != DONE)`, combinational.
- `readdataM` changes only on a load ACCESS edge. It holds its value through stores, idle cycles and errors.
- Abort: if `memenM` falls in BUSY or ACCESS, return to IDLE next edge with no write and no `readdataM` update.
- Array contents are not reset and are uninitialised after power-up.

## Timing
- Reset values: state=IDLE, counter=0, `readdataM=32'h0`. `memstallM` and `addrerrM` are 0 while `rst=0`.
- Reset mid-access: any pending store is dropped; the array is unchanged.
- Accepted request is presented at cycle 0:
  - `memstallM` is high for cycles 0..`WAIT_CYCLES`+1 and low in cycle `WAIT_CYCLES`+2 (DONE).
  - Stall count = `WAIT_CYCLES`+2.
- Store data is visible to a load issued in any later request.
- A new request is accepted at the earliest in the cycle after DONE. Back-to-back requests each take the full latency.

## Test plan
- **Reset with stimulus present**: hold `rst=0` with `memenM=1` driven → `memstallM=0`, `addrerrM=0`, `readdataM=0`. Release `rst` → the request is accepted next cycle.
- **Word round trip, `WAIT_CYCLES=2`**: store `32'hDEADBEEF` at `0x40`, `selM=1111`, then load `0x40`.
  - Each access stalls exactly 4 cycles.
  - `readdataM=32'hDEADBEEF` in the load's DONE cycle.
- **Byte lanes**: word store `32'h11223344` at `0x8`, then byte store `selM=0100`, `writedataM=32'h00AA0000` at `0xA`. Reload `0x8` → `32'h11AA3344`.
- **Misaligned**: `aluoutM=0x2`, `selM=1111`, `memenM=1` → `addrerrM=1`, `memstallM=0` the same cycle; a subsequent load of `0x0` shows unchanged contents.
- **Abort, `WAIT_CYCLES=3`**: drop `memenM` during BUSY of a store to `0x10` → the word at `0x10` keeps its old value; the FSM is back in IDLE one cycle later.
- **`WAIT_CYCLES=0` and address alias**: with `ADDR_WIDTH=10`, store at `0x1004`, then load `0x0004` → the stored word is returned, with a 2-cycle stall per access.
